// File: rtl/id_stage_pipe.sv
// RV32I/RV32E decode stage: register file, operand forwarding, load-use interlock,
// optional branch/JALR resolution in ID, and a registered ID/EX output register.
module id_stage_pipe #(
  parameter int XLEN         = 32,
  parameter int NREG         = 32,
  parameter int BRANCH_IN_ID = 1,
  parameter int MEM_LOAD_FWD = 1,
  localparam int RW          = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_in,
  input  logic            flush_in,
  input  logic            ifid_valid,
  input  logic [31:0]     ifid_inst,
  input  logic [XLEN-1:0] ifid_pc,
  input  logic            wb_we,
  input  logic [RW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_we,
  input  logic [RW-1:0]   ex_addr,
  input  logic [XLEN-1:0] ex_data,
  input  logic            ex_is_load,
  input  logic            mem_we,
  input  logic [RW-1:0]   mem_addr,
  input  logic [XLEN-1:0] mem_data,
  input  logic            mem_is_load,
  output logic            id_stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            idex_valid,
  output logic [XLEN-1:0] idex_pc,
  output logic [4:0]      idex_op,
  output logic [XLEN-1:0] idex_rs1,
  output logic [XLEN-1:0] idex_rs2,
  output logic [XLEN-1:0] idex_imm,
  output logic [RW-1:0]   idex_rd,
  output logic            idex_we,
  output logic            idex_use_imm,
  output logic            idex_illegal
);
  localparam int AW = (NREG > 16) ? 5 : 4;

  localparam logic [4:0] OP_NOP = 5'd0,  OP_ADD = 5'd1,  OP_SUB = 5'd2,  OP_SLL = 5'd3;
  localparam logic [4:0] OP_SLT = 5'd4,  OP_SLTU = 5'd5, OP_XOR = 5'd6,  OP_SRL = 5'd7;
  localparam logic [4:0] OP_SRA = 5'd8,  OP_OR = 5'd9,   OP_AND = 5'd10, OP_LUI = 5'd11;
  localparam logic [4:0] OP_AUIPC = 5'd12, OP_JAL = 5'd13, OP_JALR = 5'd14, OP_BEQ = 5'd15;
  localparam logic [4:0] OP_BNE = 5'd16, OP_BLT = 5'd17, OP_BGE = 5'd18,  OP_BLTU = 5'd19;
  localparam logic [4:0] OP_BGEU = 5'd20, OP_LB = 5'd21, OP_LH = 5'd22,   OP_LW = 5'd23;
  localparam logic [4:0] OP_LBU = 5'd24, OP_LHU = 5'd25, OP_SB = 5'd26,   OP_SH = 5'd27;
  localparam logic [4:0] OP_SW = 5'd28;

  function automatic logic in_rng(input logic [RW-1:0] r);
    return int'(r) < NREG;
  endfunction

  logic [XLEN-1:0] rf [NREG];

  logic [6:0]    opc, f7;
  logic [2:0]    f3;
  logic [RW-1:0] rs1_a, rs2_a, rd_a;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;

  assign opc   = ifid_inst[6:0];
  assign rd_a  = ifid_inst[11:7];
  assign f3    = ifid_inst[14:12];
  assign rs1_a = ifid_inst[19:15];
  assign rs2_a = ifid_inst[24:20];
  assign f7    = ifid_inst[31:25];
  assign imm_i = {{20{ifid_inst[31]}}, ifid_inst[31:20]};
  assign imm_s = {{20{ifid_inst[31]}}, ifid_inst[31:25], ifid_inst[11:7]};
  assign imm_b = {{19{ifid_inst[31]}}, ifid_inst[31], ifid_inst[7], ifid_inst[30:25], ifid_inst[11:8], 1'b0};
  assign imm_u = {ifid_inst[31:12], 12'b0};
  assign imm_j = {{11{ifid_inst[31]}}, ifid_inst[31], ifid_inst[19:12], ifid_inst[20], ifid_inst[30:21], 1'b0};
  assign shamt = {27'b0, ifid_inst[24:20]};

  logic [4:0]      dec_op;
  logic [XLEN-1:0] dec_imm;
  logic dec_ok, need1, need2, needd, dec_ui, is_br, is_jal, is_jalr;

  always_comb begin
    dec_op = OP_NOP; dec_imm = '0; dec_ok = 1'b1;
    need1 = 1'b0; need2 = 1'b0; needd = 1'b0; dec_ui = 1'b0;
    is_br = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    case (opc)
      7'b0110111: begin dec_op = OP_LUI;   dec_imm = imm_u; needd = 1'b1; dec_ui = 1'b1; end
      7'b0010111: begin dec_op = OP_AUIPC; dec_imm = imm_u; needd = 1'b1; dec_ui = 1'b1; end
      7'b1101111: begin dec_op = OP_JAL; dec_imm = 32'd4; needd = 1'b1; dec_ui = 1'b1; is_jal = 1'b1; end
      7'b1100111: begin
        dec_op = OP_JALR; need1 = 1'b1; needd = 1'b1; dec_ui = 1'b1; is_jalr = 1'b1;
        dec_imm = (BRANCH_IN_ID != 0) ? 32'd4 : imm_i;
        dec_ok = (f3 == 3'b000);
      end
      7'b1100011: begin
        need1 = 1'b1; need2 = 1'b1; is_br = 1'b1; dec_imm = imm_b;
        case (f3)
          3'b000: dec_op = OP_BEQ;  3'b001: dec_op = OP_BNE;
          3'b100: dec_op = OP_BLT;  3'b101: dec_op = OP_BGE;
          3'b110: dec_op = OP_BLTU; 3'b111: dec_op = OP_BGEU;
          default: dec_ok = 1'b0;
        endcase
      end
      7'b0000011: begin
        need1 = 1'b1; needd = 1'b1; dec_ui = 1'b1; dec_imm = imm_i;
        case (f3)
          3'b000: dec_op = OP_LB;  3'b001: dec_op = OP_LH; 3'b010: dec_op = OP_LW;
          3'b100: dec_op = OP_LBU; 3'b101: dec_op = OP_LHU;
          default: dec_ok = 1'b0;
        endcase
      end
      7'b0100011: begin
        need1 = 1'b1; need2 = 1'b1; dec_ui = 1'b1; dec_imm = imm_s;
        case (f3)
          3'b000: dec_op = OP_SB; 3'b001: dec_op = OP_SH; 3'b010: dec_op = OP_SW;
          default: dec_ok = 1'b0;
        endcase
      end
      7'b0010011: begin
        need1 = 1'b1; needd = 1'b1; dec_ui = 1'b1; dec_imm = imm_i;
        case (f3)
          3'b000: dec_op = OP_ADD;  3'b010: dec_op = OP_SLT; 3'b011: dec_op = OP_SLTU;
          3'b100: dec_op = OP_XOR;  3'b110: dec_op = OP_OR;  3'b111: dec_op = OP_AND;
          3'b001: begin dec_op = OP_SLL; dec_imm = shamt; dec_ok = (f7 == 7'b0000000); end
          default: begin
            dec_imm = shamt;
            if (f7 == 7'b0000000)      dec_op = OP_SRL;
            else if (f7 == 7'b0100000) dec_op = OP_SRA;
            else                       dec_ok = 1'b0;
          end
        endcase
      end
      7'b0110011: begin
        need1 = 1'b1; need2 = 1'b1; needd = 1'b1;
        case ({f7, f3})
          10'b0000000_000: dec_op = OP_ADD;  10'b0100000_000: dec_op = OP_SUB;
          10'b0000000_001: dec_op = OP_SLL;  10'b0000000_010: dec_op = OP_SLT;
          10'b0000000_011: dec_op = OP_SLTU; 10'b0000000_100: dec_op = OP_XOR;
          10'b0000000_101: dec_op = OP_SRL;  10'b0100000_101: dec_op = OP_SRA;
          10'b0000000_110: dec_op = OP_OR;   10'b0000000_111: dec_op = OP_AND;
          default: dec_ok = 1'b0;
        endcase
      end
      default: dec_ok = 1'b0;
    endcase
  end

  logic ill_p0, use1, use2, lu1, lu2, vld_p0, we_p0, ui_p0, br_cond, take;
  logic [4:0]      op_p0;
  logic [RW-1:0]   rd_p0;
  logic [XLEN-1:0] imm_p0, rs1_p0, rs2_p0, target;
  logic signed [XLEN-1:0] a_s, b_s;

  assign ill_p0 = !dec_ok || (need1 && !in_rng(rs1_a)) || (need2 && !in_rng(rs2_a)) ||
                  (needd && !in_rng(rd_a));
  assign use1   = need1 && !ill_p0 && (rs1_a != '0);
  assign use2   = need2 && !ill_p0 && (rs2_a != '0);
  assign op_p0  = ill_p0 ? OP_NOP : dec_op;
  assign imm_p0 = ill_p0 ? '0 : dec_imm;
  assign we_p0  = !ill_p0 && needd;
  assign ui_p0  = !ill_p0 && dec_ui;
  assign rd_p0  = we_p0 ? rd_a : '0;

  // Youngest producer wins: EX, then MEM, then WB (same-cycle write bypass), then regfile
  assign rs1_p0 = !use1 ? '0 :
                  (ex_we  && ex_addr  == rs1_a) ? ex_data  :
                  (mem_we && mem_addr == rs1_a) ? mem_data :
                  (wb_we  && wb_addr  == rs1_a) ? wb_data  : rf[rs1_a[AW-1:0]];
  assign rs2_p0 = !use2 ? '0 :
                  (ex_we  && ex_addr  == rs2_a) ? ex_data  :
                  (mem_we && mem_addr == rs2_a) ? mem_data :
                  (wb_we  && wb_addr  == rs2_a) ? wb_data  : rf[rs2_a[AW-1:0]];

  assign lu1 = use1 && ((ex_we && ex_is_load && ex_addr == rs1_a) ||
               ((MEM_LOAD_FWD == 0) && mem_we && mem_is_load && mem_addr == rs1_a));
  assign lu2 = use2 && ((ex_we && ex_is_load && ex_addr == rs2_a) ||
               ((MEM_LOAD_FWD == 0) && mem_we && mem_is_load && mem_addr == rs2_a));
  assign id_stall = !rst && ifid_valid && !flush_in && (lu1 || lu2);
  assign vld_p0   = ifid_valid && !flush_in && !id_stall;

  assign a_s = rs1_p0;
  assign b_s = rs2_p0;
  always_comb begin
    br_cond = 1'b0;
    case (dec_op)
      OP_BEQ:  br_cond = (rs1_p0 == rs2_p0);
      OP_BNE:  br_cond = (rs1_p0 != rs2_p0);
      OP_BLT:  br_cond = (a_s < b_s);
      OP_BGE:  br_cond = (a_s >= b_s);
      OP_BLTU: br_cond = (rs1_p0 < rs2_p0);
      OP_BGEU: br_cond = (rs1_p0 >= rs2_p0);
      default: br_cond = 1'b0;
    endcase
  end

  logic [XLEN-1:0] jalr_sum;
  assign jalr_sum = rs1_p0 + imm_i;
  assign target   = is_jal  ? ifid_pc + imm_j :
                    is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : ifid_pc + imm_b;
  assign take     = !ill_p0 && (is_jal || ((BRANCH_IN_ID != 0) && (is_jalr || (is_br && br_cond))));
  assign redirect_valid = !rst && ifid_valid && !id_stall && !flush_in && !stall_in && take;
  assign redirect_pc    = redirect_valid ? target : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_we && wb_addr != '0 && in_rng(wb_addr)) begin
      rf[wb_addr[AW-1:0]] <= wb_data;
    end
  end

  // ID/EX register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_valid <= 1'b0; idex_pc <= '0; idex_op <= OP_NOP; idex_rs1 <= '0; idex_rs2 <= '0;
      idex_imm <= '0; idex_rd <= '0; idex_we <= 1'b0; idex_use_imm <= 1'b0; idex_illegal <= 1'b0;
    end else if (stall_in) begin
      idex_valid <= idex_valid;
    end else if (!vld_p0) begin
      idex_valid <= 1'b0; idex_we <= 1'b0; idex_op <= OP_NOP; idex_illegal <= 1'b0;
    end else begin
      idex_valid <= 1'b1;     idex_pc <= ifid_pc;   idex_op <= op_p0;
      idex_rs1 <= rs1_p0;     idex_rs2 <= rs2_p0;   idex_imm <= imm_p0;
      idex_rd <= rd_p0;       idex_we <= we_p0;     idex_use_imm <= ui_p0;
      idex_illegal <= ill_p0;
    end
  end
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe (RV32E instance): expected ID/EX contents are queued
// when each instruction is presented and checked one edge later.
module tb_id_stage_pipe;
  logic        clk = 1'b0;
  logic        rst, stall_in, flush_in, ifid_valid;
  logic [31:0] ifid_inst, ifid_pc;
  logic        wb_we, ex_we, ex_is_load, mem_we, mem_is_load;
  logic [4:0]  wb_addr, ex_addr, mem_addr;
  logic [31:0] wb_data, ex_data, mem_data;
  logic        id_stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        idex_valid, idex_we, idex_use_imm, idex_illegal;
  logic [31:0] idex_pc, idex_rs1, idex_rs2, idex_imm;
  logic [4:0]  idex_op, idex_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(32), .NREG(16), .BRANCH_IN_ID(1), .MEM_LOAD_FWD(1)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
    .ifid_valid(ifid_valid), .ifid_inst(ifid_inst), .ifid_pc(ifid_pc),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_we(ex_we), .ex_addr(ex_addr), .ex_data(ex_data), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_is_load(mem_is_load),
    .id_stall(id_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_op(idex_op), .idex_rs1(idex_rs1),
    .idex_rs2(idex_rs2), .idex_imm(idex_imm), .idex_rd(idex_rd), .idex_we(idex_we),
    .idex_use_imm(idex_use_imm), .idex_illegal(idex_illegal)
  );

  typedef struct {
    logic v; logic [31:0] pc; logic [4:0] op; logic [31:0] a, b, imm;
    logic [4:0] rd; logic we, ui, ill;
  } exp_t;

  exp_t sb[$];
  exp_t last;

  function automatic exp_t mk(logic v, logic [31:0] pc, logic [4:0] op, logic [31:0] a, b, imm,
                              logic [4:0] rd, logic we, ui, ill);
    exp_t e;
    e.v = v; e.pc = pc; e.op = op; e.a = a; e.b = b; e.imm = imm;
    e.rd = rd; e.we = we; e.ui = ui; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t bub(exp_t p);
    exp_t e = p;
    e.v = 1'b0; e.we = 1'b0; e.op = 5'd0; e.ill = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] r_t(logic [6:0] f7, logic [4:0] rs2, rs1, logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_t(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] s_t(logic [11:0] imm, logic [4:0] rs2, rs1, logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] b_t(logic [12:0] imm, logic [4:0] rs2, rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] j_t(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    stall_in = 0; flush_in = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0;
    ex_we = 0; ex_addr = 0; ex_data = 0; ex_is_load = 0;
    mem_we = 0; mem_addr = 0; mem_data = 0; mem_is_load = 0;
  endtask

  task automatic fetch(logic v, logic [31:0] inst, logic [31:0] pc);
    ifid_valid = v; ifid_inst = inst; ifid_pc = pc;
  endtask

  // Inputs are already driven; check combinational outputs, queue the ID/EX expectation,
  // then pop and compare it after the next clock edge.
  task automatic step(string tag, exp_t e, logic e_stall, logic e_rv, logic [31:0] e_rpc);
    exp_t g;
    #1;
    chk({tag, ".id_stall"}, id_stall, e_stall);
    chk({tag, ".redirect_valid"}, redirect_valid, e_rv);
    chk({tag, ".redirect_pc"}, redirect_pc, e_rpc);
    sb.push_back(e);
    last = e;
    @(posedge clk);
    #1;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      n_tests--;
      g = sb.pop_front();
      chk({tag, ".valid"}, idex_valid, g.v);
      chk({tag, ".pc"}, idex_pc, g.pc);
      chk({tag, ".op"}, idex_op, g.op);
      chk({tag, ".rs1"}, idex_rs1, g.a);
      chk({tag, ".rs2"}, idex_rs2, g.b);
      chk({tag, ".imm"}, idex_imm, g.imm);
      chk({tag, ".rd"}, idex_rd, g.rd);
      chk({tag, ".we"}, idex_we, g.we);
      chk({tag, ".use_imm"}, idex_use_imm, g.ui);
      chk({tag, ".illegal"}, idex_illegal, g.ill);
    end
  endtask

  initial begin
    exp_t z;
    logic [31:0] jal_i;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1; quiet(); fetch(0, 32'h0, 32'h0);
    @(posedge clk); #1;
    step("reset", z, 0, 0, 0);
    rst = 0;

    fetch(1, i_t(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'h0);
    step("addi", mk(1, 32'h0, 5'd1, 0, 0, 5, 5'd1, 1, 1, 0), 0, 0, 0);

    quiet(); ex_we = 1; ex_addr = 1; ex_data = 5;
    fetch(1, r_t(7'd0, 5'd1, 5'd1, 3'b000, 5'd2), 32'h4);
    step("add_exfwd", mk(1, 32'h4, 5'd1, 5, 5, 0, 5'd2, 1, 0, 0), 0, 0, 0);

    ex_data = 32'h11; mem_we = 1; mem_addr = 1; mem_data = 32'h22;
    wb_we = 1; wb_addr = 1; wb_data = 32'h33;
    fetch(1, r_t(7'd0, 5'd1, 5'd1, 3'b000, 5'd2), 32'h8);
    step("prio_ex", mk(1, 32'h8, 5'd1, 32'h11, 32'h11, 0, 5'd2, 1, 0, 0), 0, 0, 0);

    ex_we = 0;
    step("prio_mem", mk(1, 32'h8, 5'd1, 32'h22, 32'h22, 0, 5'd2, 1, 0, 0), 0, 0, 0);

    quiet(); wb_we = 1; wb_addr = 1; wb_data = 32'h55;
    step("wb_bypass", mk(1, 32'h8, 5'd1, 32'h55, 32'h55, 0, 5'd2, 1, 0, 0), 0, 0, 0);

    quiet();
    step("rf_read", mk(1, 32'h8, 5'd1, 32'h55, 32'h55, 0, 5'd2, 1, 0, 0), 0, 0, 0);

    ex_we = 1; ex_addr = 3; ex_is_load = 1; ex_data = 32'hDEAD;
    fetch(1, r_t(7'b0100000, 5'd0, 5'd3, 3'b000, 5'd4), 32'h10);
    step("loaduse", bub(last), 1, 0, 0);

    quiet(); mem_we = 1; mem_addr = 3; mem_data = 7; mem_is_load = 1;
    step("memload_fwd", mk(1, 32'h10, 5'd2, 7, 0, 0, 5'd4, 1, 0, 0), 0, 0, 0);

    quiet(); wb_we = 1; wb_addr = 5; wb_data = 32'h203; fetch(0, 32'h0, 32'h14);
    step("novalid", bub(last), 0, 0, 0);

    wb_addr = 0; wb_data = 32'hFFFF;
    step("wb_x0", bub(last), 0, 0, 0);

    quiet();
    fetch(1, b_t(13'd16, 5'd0, 5'd0, 3'b000), 32'h100);
    step("beq", mk(1, 32'h100, 5'd15, 0, 0, 16, 0, 0, 0, 0), 0, 1, 32'h110);

    fetch(1, b_t(13'd16, 5'd0, 5'd0, 3'b001), 32'h104);
    step("bne", mk(1, 32'h104, 5'd16, 0, 0, 16, 0, 0, 0, 0), 0, 0, 0);

    fetch(1, b_t(13'h1FF8, 5'd5, 5'd1, 3'b100), 32'h200);
    step("blt", mk(1, 32'h200, 5'd17, 32'h55, 32'h203, 32'hFFFFFFF8, 0, 0, 0, 0), 0, 1, 32'h1F8);

    fetch(1, i_t(12'd8, 5'd5, 3'b000, 5'd1, 7'b1100111), 32'h100);
    step("jalr", mk(1, 32'h100, 5'd14, 32'h203, 0, 4, 5'd1, 1, 1, 0), 0, 1, 32'h20A);

    fetch(1, i_t({7'b0100000, 5'd3}, 5'd1, 3'b101, 5'd7, 7'b0010011), 32'h120);
    step("srai", mk(1, 32'h120, 5'd8, 32'h55, 0, 3, 5'd7, 1, 1, 0), 0, 0, 0);

    fetch(1, s_t(12'hFF4, 5'd5, 5'd1, 3'b010), 32'h124);
    step("sw", mk(1, 32'h124, 5'd28, 32'h55, 32'h203, 32'hFFFFFFF4, 0, 0, 1, 0), 0, 0, 0);

    fetch(1, r_t(7'd0, 5'd1, 5'd1, 3'b000, 5'd17), 32'h128);
    step("illegal_rd", mk(1, 32'h128, 5'd0, 0, 0, 0, 0, 0, 0, 1), 0, 0, 0);

    jal_i = j_t(21'h40, 5'd1);
    stall_in = 1; fetch(1, jal_i, 32'h300);
    for (int k = 0; k < 3; k++) step("stall_hold", last, 0, 0, 0);

    stall_in = 0;
    step("jal", mk(1, 32'h300, 5'd13, 0, 0, 4, 5'd1, 1, 1, 0), 0, 1, 32'h340);

    flush_in = 1;
    step("flush_jal", bub(last), 0, 0, 0);

    ex_we = 1; ex_addr = 3; ex_is_load = 1;
    fetch(1, r_t(7'b0100000, 5'd0, 5'd3, 3'b000, 5'd4), 32'h304);
    step("flush_loaduse", bub(last), 0, 0, 0);

    flush_in = 0;
    step("loaduse2", bub(last), 1, 0, 0);

    rst = 1;
    step("rst_in_stall", z, 0, 0, 0);

    rst = 0; quiet();
    fetch(1, r_t(7'd0, 5'd0, 5'd5, 3'b000, 5'd6), 32'h400);
    step("post_reset_rf", mk(1, 32'h400, 5'd1, 0, 0, 0, 5'd6, 1, 0, 0), 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
